// File: rtl/mem_stage_if.sv
// mem_stage_if: groups the MEM-stage pipeline handshake and bus signals.
//   slave  modport: used by mem_stage (consumes EXE bus and SRAM data,
//                   produces WB bundle, forward bus and status).
//   master modport: used by the surrounding pipeline / testbench.
interface mem_stage_if #(
  parameter int ES_TO_MS_BUS_WD = 160,
  parameter int MS_TO_WS_BUS_WD = 120,
  parameter int FW_BUS_WD       = 39
);
  logic                       ws_allowin;
  logic                       ms_allowin;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
  logic [FW_BUS_WD-1:0]       ms_to_ds_fw_bus;
  logic                       out_ms_valid;
  logic                       ms_excp_valid;
  logic                       ws_flush;
  logic [31:0]                data_sram_rdata;

  modport slave (
    input  ws_allowin, es_to_ms_valid, es_to_ms_bus, ws_flush, data_sram_rdata,
    output ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_fw_bus,
           out_ms_valid, ms_excp_valid
  );

  modport master (
    output ws_allowin, es_to_ms_valid, es_to_ms_bus, ws_flush, data_sram_rdata,
    input  ms_allowin, ms_to_ws_valid, ms_to_ws_bus, ms_to_ds_fw_bus,
           out_ms_valid, ms_excp_valid
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: fourth pipeline stage. Latches the EXE-to-MEM bundle, aligns
// load data from the synchronous data SRAM, forwards results to decode and
// hands the bundle to WB with a valid/allowin handshake.
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - asynchronous active-high reset
//   ms     - mem_stage_if.slave: EXE bus in, SRAM read data in, WB bundle
//            out, decode forward bus out, flush in, status out
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 160,
  parameter int MS_TO_WS_BUS_WD = 120,
  parameter int FW_BUS_WD       = 39
) (
  input  logic        clk,
  input  logic        reset,
  mem_stage_if.slave  ms
);

  logic                       ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] bus_r;
  logic                       first_cycle;
  logic [31:0]                rdata_buf;
  logic                       buf_valid;

  logic ms_ready_go;
  logic accept;

  assign ms_ready_go    = 1'b1;
  assign ms.ms_allowin  = !ms_valid || (ms_ready_go && ms.ws_allowin);
  assign ms.ms_to_ws_valid = ms_valid && ms_ready_go;
  assign ms.out_ms_valid   = ms_valid;
  assign accept = ms.es_to_ms_valid && ms.ms_allowin && !ms.ws_flush;

  // Latched bus fields
  logic        eret, mfc0, excp_valid;
  logic [31:0] rt_value;
  logic        op_wl, op_wr, op_w, op_bu, op_b, op_hu, op_h;
  logic        res_from_mem, gr_we;
  logic [4:0]  dest;
  logic [31:0] result, pc;

  assign eret         = bus_r[118];
  assign mfc0         = bus_r[116];
  assign excp_valid   = bus_r[115];
  assign rt_value     = bus_r[109:78];
  assign op_wl        = bus_r[77];
  assign op_wr        = bus_r[76];
  assign op_w         = bus_r[75];
  assign op_bu        = bus_r[74];
  assign op_b         = bus_r[73];
  assign op_hu        = bus_r[72];
  assign op_h         = bus_r[71];
  assign res_from_mem = bus_r[70];
  assign gr_we        = bus_r[69];
  assign dest         = bus_r[68:64];
  assign result       = bus_r[63:32];
  assign pc           = bus_r[31:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid    <= 1'b0;
      bus_r       <= '0;
      first_cycle <= 1'b0;
      rdata_buf   <= '0;
      buf_valid   <= 1'b0;
    end else begin
      if (ms.ws_flush) begin
        ms_valid <= 1'b0;
      end else if (ms.ms_allowin) begin
        ms_valid <= ms.es_to_ms_valid;
      end

      if (accept) begin
        bus_r       <= ms.es_to_ms_bus;
        first_cycle <= 1'b1;
        buf_valid   <= 1'b0;
      end else begin
        first_cycle <= 1'b0;
        if (ms.ws_flush) begin
          buf_valid <= 1'b0;
        end else if (ms_valid && first_cycle && !ms.ws_allowin) begin
          // SRAM data is only valid in the entry cycle; keep it for the stall.
          rdata_buf <= ms.data_sram_rdata;
          buf_valid <= 1'b1;
        end
      end
    end
  end

  logic [31:0] rdata;
  logic [1:0]  k;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] final_result;

  assign rdata = buf_valid ? rdata_buf : ms.data_sram_rdata;
  assign k     = result[1:0];

  always_comb begin
    byte_sel = rdata[7:0];
    case (k)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = k[1] ? rdata[31:16] : rdata[15:0];

    load_val = rdata;
    if (op_b) begin
      load_val = {{24{byte_sel[7]}}, byte_sel};
    end else if (op_bu) begin
      load_val = {24'h0, byte_sel};
    end else if (op_h) begin
      load_val = {{16{half_sel[15]}}, half_sel};
    end else if (op_hu) begin
      load_val = {16'h0, half_sel};
    end else if (op_wl) begin
      case (k)
        2'd0: load_val = {rdata[7:0],  rt_value[23:0]};
        2'd1: load_val = {rdata[15:0], rt_value[15:0]};
        2'd2: load_val = {rdata[23:0], rt_value[7:0]};
        default: load_val = rdata;
      endcase
    end else if (op_wr) begin
      case (k)
        2'd1: load_val = {rt_value[31:24], rdata[31:8]};
        2'd2: load_val = {rt_value[31:16], rdata[31:16]};
        2'd3: load_val = {rt_value[31:8],  rdata[31:24]};
        default: load_val = rdata;
      endcase
    end else if (op_w) begin
      load_val = rdata;
    end
  end

  assign final_result = res_from_mem ? load_val : result;

  logic gr_we_out;
  assign gr_we_out = gr_we && !excp_valid;

  // bus_r[159:110] (bvaddr .. execode) passes straight through to WB.
  assign ms.ms_to_ws_bus = {bus_r[159:110], gr_we_out, dest, final_result, pc};

  assign ms.ms_excp_valid = ms_valid && (excp_valid || eret);

  assign ms.ms_to_ds_fw_bus = {ms_valid && mfc0, ms_valid && gr_we_out, dest,
                               final_result};

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_stage_if #(.ES_TO_MS_BUS_WD(160), .MS_TO_WS_BUS_WD(120), .FW_BUS_WD(39)) bif ();

  mem_stage #(.ES_TO_MS_BUS_WD(160), .MS_TO_WS_BUS_WD(120), .FW_BUS_WD(39)) dut (
    .clk   (clk),
    .reset (reset),
    .ms    (bif)
  );

  int checks = 0;
  int failures = 0;

  localparam logic [6:0] OP_WL = 7'b1000000;
  localparam logic [6:0] OP_WR = 7'b0100000;
  localparam logic [6:0] OP_W  = 7'b0010000;
  localparam logic [6:0] OP_BU = 7'b0001000;
  localparam logic [6:0] OP_B  = 7'b0000100;
  localparam logic [6:0] OP_HU = 7'b0000010;
  localparam logic [6:0] OP_H  = 7'b0000001;
  localparam logic [6:0] OP_NONE = 7'b0000000;

  typedef struct {
    logic [6:0]  op;
    logic        rfm;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] make_bus(input logic [31:0] pc, input logic [31:0] res,
                                            input logic [4:0] dest, input logic gr_we,
                                            input logic rfm, input logic [6:0] op,
                                            input logic [31:0] rt);
    logic [159:0] b;
    b = '0;
    b[31:0]    = pc;
    b[63:32]   = res;
    b[68:64]   = dest;
    b[69]      = gr_we;
    b[70]      = rfm;
    b[77:71]   = op;
    b[109:78]  = rt;
    return b;
  endfunction

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{OP_W,    1'b1, 32'h10000004, 32'h0,        32'h8899AABB, 32'h8899AABB};
    vecs[1]  = '{OP_B,    1'b1, 32'h10000003, 32'h0,        32'h80112233, 32'hFFFFFF80};
    vecs[2]  = '{OP_BU,   1'b1, 32'h10000003, 32'h0,        32'h80112233, 32'h00000080};
    vecs[3]  = '{OP_H,    1'b1, 32'h10000002, 32'h0,        32'h80112233, 32'hFFFF8011};
    vecs[4]  = '{OP_HU,   1'b1, 32'h10000002, 32'h0,        32'h80112233, 32'h00008011};
    vecs[5]  = '{OP_B,    1'b1, 32'h10000000, 32'h0,        32'h80112233, 32'h00000033};
    vecs[6]  = '{OP_H,    1'b1, 32'h10000000, 32'h0,        32'h1234F678, 32'hFFFFF678};
    vecs[7]  = '{OP_WL,   1'b1, 32'h10000001, 32'h11223344, 32'hAABBCCDD, 32'hCCDD3344};
    vecs[8]  = '{OP_WR,   1'b1, 32'h10000002, 32'h11223344, 32'hAABBCCDD, 32'h1122AABB};
    vecs[9]  = '{OP_WL,   1'b1, 32'h10000000, 32'h11223344, 32'hAABBCCDD, 32'hDD223344};
    vecs[10] = '{OP_WL,   1'b1, 32'h10000003, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD};
    vecs[11] = '{OP_WR,   1'b1, 32'h10000000, 32'h11223344, 32'hAABBCCDD, 32'hAABBCCDD};
    vecs[12] = '{OP_WR,   1'b1, 32'h10000003, 32'h11223344, 32'hAABBCCDD, 32'h112233AA};
    vecs[13] = '{OP_WR,   1'b1, 32'h10000001, 32'h11223344, 32'hAABBCCDD, 32'h11AABBCC};
    vecs[14] = '{OP_WL,   1'b1, 32'h10000002, 32'h11223344, 32'hAABBCCDD, 32'hBBCCDD44};
    vecs[15] = '{OP_NONE, 1'b0, 32'h12345678, 32'h0,        32'hCAFEF00D, 32'h12345678};
    vecs[16] = '{OP_B,    1'b1, 32'h10000001, 32'h0,        32'h80112233, 32'h00000022};
    vecs[17] = '{OP_BU,   1'b1, 32'h10000002, 32'h0,        32'h80112233, 32'h00000011};

    reset = 1'b1;
    bif.ws_allowin      = 1'b1;
    bif.es_to_ms_valid  = 1'b0;
    bif.es_to_ms_bus    = '0;
    bif.ws_flush        = 1'b0;
    bif.data_sram_rdata = '0;
    #12;
    chk("reset_ms_allowin", {31'h0, bif.ms_allowin}, 32'h1);
    chk("reset_ws_valid", {31'h0, bif.ms_to_ws_valid}, 32'h0);
    chk("reset_excp_valid", {31'h0, bif.ms_excp_valid}, 32'h0);
    chk("reset_fw_flags", {30'h0, bif.ms_to_ds_fw_bus[38:37]}, 32'h0);
    chk("reset_ws_bus_hi", bif.ms_to_ws_bus[119:88], 32'h0);
    reset = 1'b0;

    // Table-driven alignment vectors, one instruction at a time.
    for (int i = 0; i < 18; i++) begin
      to_drive();
      bif.es_to_ms_valid = 1'b1;
      bif.es_to_ms_bus   = make_bus(32'hBFC00000 + 32'(i * 4), vecs[i].addr, 5'(i + 1),
                                    1'b1, vecs[i].rfm, vecs[i].op, vecs[i].rt);
      bif.ws_allowin     = 1'b1;
      to_drive();
      bif.es_to_ms_valid  = 1'b0;
      bif.data_sram_rdata = vecs[i].rdata;
      to_sample();
      chk($sformatf("v%0d_final", i), bif.ms_to_ws_bus[63:32], vecs[i].exp);
      chk($sformatf("v%0d_fw_result", i), bif.ms_to_ds_fw_bus[31:0], vecs[i].exp);
      chk($sformatf("v%0d_valid_gr_we_dest", i),
          {25'h0, bif.ms_to_ws_valid, bif.ms_to_ws_bus[69], bif.ms_to_ws_bus[68:64]},
          {25'h0, 1'b1, 1'b1, 5'(i + 1)});
      chk($sformatf("v%0d_pc", i), bif.ms_to_ws_bus[31:0], 32'hBFC00000 + 32'(i * 4));
      to_drive();
      to_sample();
      chk($sformatf("v%0d_drained", i), {31'h0, bif.ms_to_ws_valid}, 32'h0);
    end

    // Stall: entry cycle + 3 stalled cycles, SRAM data changes after entry.
    to_drive();
    bif.es_to_ms_valid = 1'b1;
    bif.es_to_ms_bus   = make_bus(32'hBFC01000, 32'h10000008, 5'd7, 1'b1, 1'b1, OP_W, 32'h0);
    to_drive();
    bif.es_to_ms_valid  = 1'b0;
    bif.data_sram_rdata = 32'h01020304;
    bif.ws_allowin      = 1'b0;
    to_sample();
    chk("stall_c0_final", bif.ms_to_ws_bus[63:32], 32'h01020304);
    chk("stall_c0_allowin", {31'h0, bif.ms_allowin}, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      to_drive();
      bif.data_sram_rdata = 32'hDEADBEEF;
      if (c == 3) begin
        bif.ws_allowin     = 1'b1;
        // Back-to-back: next load waits to enter on the release edge.
        bif.es_to_ms_valid = 1'b1;
        bif.es_to_ms_bus   = make_bus(32'hBFC01004, 32'h1000000C, 5'd8, 1'b1, 1'b1, OP_W, 32'h0);
      end
      to_sample();
      chk($sformatf("stall_c%0d_final", c), bif.ms_to_ws_bus[63:32], 32'h01020304);
      chk($sformatf("stall_c%0d_valid", c), {31'h0, bif.ms_to_ws_valid}, 32'h1);
      chk($sformatf("stall_c%0d_allowin", c), {31'h0, bif.ms_allowin}, (c == 3) ? 32'h1 : 32'h0);
    end
    to_drive();
    bif.es_to_ms_valid  = 1'b0;
    bif.data_sram_rdata = 32'h55667788;
    to_sample();
    chk("b2b_pc", bif.ms_to_ws_bus[31:0], 32'hBFC01004);
    chk("b2b_fresh_rdata", bif.ms_to_ws_bus[63:32], 32'h55667788);
    to_drive();
    to_sample();
    chk("b2b_drained", {31'h0, bif.ms_to_ws_valid}, 32'h0);

    // Exception bundle held by WB back-pressure, then flushed.
    to_drive();
    bif.es_to_ms_valid = 1'b1;
    bif.es_to_ms_bus   = make_bus(32'hBFC02000, 32'h00000040, 5'd9, 1'b1, 1'b0, OP_NONE, 32'h0);
    bif.es_to_ms_bus[115]     = 1'b1;
    bif.es_to_ms_bus[114:110] = 5'h04;
    bif.es_to_ms_bus[159:128] = 32'h00000041;
    to_drive();
    bif.es_to_ms_valid = 1'b0;
    bif.ws_allowin     = 1'b0;
    to_sample();
    chk("excp_gr_we", {31'h0, bif.ms_to_ws_bus[69]}, 32'h0);
    chk("excp_ms_excp_valid", {31'h0, bif.ms_excp_valid}, 32'h1);
    chk("excp_execode", {27'h0, bif.ms_to_ws_bus[74:70]}, 32'h4);
    chk("excp_bvaddr", bif.ms_to_ws_bus[119:88], 32'h00000041);
    chk("excp_fw_gr_we", {31'h0, bif.ms_to_ds_fw_bus[37]}, 32'h0);
    to_drive();
    bif.ws_flush = 1'b1;
    to_drive();
    bif.ws_flush = 1'b0;
    to_sample();
    chk("flush_empty", {31'h0, bif.ms_to_ws_valid}, 32'h0);
    chk("flush_excp_clear", {31'h0, bif.ms_excp_valid}, 32'h0);

    // Flush arriving together with a new instruction.
    bif.ws_allowin = 1'b1;
    to_drive();
    bif.es_to_ms_valid = 1'b1;
    bif.ws_flush       = 1'b1;
    bif.es_to_ms_bus   = make_bus(32'hBFC03000, 32'h0, 5'd3, 1'b1, 1'b0, OP_NONE, 32'h0);
    to_drive();
    bif.es_to_ms_valid = 1'b0;
    bif.ws_flush       = 1'b0;
    to_sample();
    chk("flush_vs_accept", {31'h0, bif.out_ms_valid}, 32'h0);

    // mfc0 raises the decode stall flag.
    to_drive();
    bif.es_to_ms_valid = 1'b1;
    bif.es_to_ms_bus   = make_bus(32'hBFC04000, 32'h0, 5'd4, 1'b1, 1'b0, OP_NONE, 32'h0);
    bif.es_to_ms_bus[116] = 1'b1;
    to_drive();
    bif.es_to_ms_valid = 1'b0;
    to_sample();
    chk("mfc0_fw_flags", {30'h0, bif.ms_to_ds_fw_bus[38:37]}, 32'h3);
    to_drive();
    to_sample();
    chk("mfc0_flag_drained", {31'h0, bif.ms_to_ds_fw_bus[38]}, 32'h0);

    // Async reset in the middle of a stall.
    to_drive();
    bif.es_to_ms_valid = 1'b1;
    bif.es_to_ms_bus   = make_bus(32'hBFC05000, 32'h10000010, 5'd5, 1'b1, 1'b1, OP_W, 32'h0);
    to_drive();
    bif.es_to_ms_valid = 1'b0;
    bif.ws_allowin     = 1'b0;
    to_drive();
    to_sample();
    chk("prereset_stalled", {30'h0, bif.ms_to_ws_valid, bif.ms_allowin}, 32'h2);
    #2;
    reset = 1'b1;
    #1;
    chk("midreset_valid", {31'h0, bif.ms_to_ws_valid}, 32'h0);
    chk("midreset_allowin", {31'h0, bif.ms_allowin}, 32'h1);
    reset = 1'b0;
    to_drive();
    to_sample();
    chk("postreset_empty", {31'h0, bif.ms_to_ws_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Fourth pipeline stage: consumes the EXE-to-MEM bus and the synchronous data-SRAM read data, extracts and aligns load data (lb/lbu/lh/lhu/lw/lwl/lwr), and forwards results to decode. It presents the retired-candidate bundle to WB with a valid/allowin handshake. A one-entry read-data hold buffer keeps load data correct while WB back-pressures.

## Interface
- ES_TO_MS_BUS_WD, 160, EXE→MEM bus width
- MS_TO_WS_BUS_WD, 120, MEM→WB bus width
- FW_BUS_WD, 39, forward bus width
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- ws_allowin  in  1  WB can accept this cycle
- ms_allowin  out  1  MEM can accept this cycle
- es_to_ms_valid  in  1  EXE presents a valid instruction
- es_to_ms_bus  in  160  {excp_bvaddr[159:128], bd[127], cp0_dest[126:119], eret[118], mtc0[117], mfc0[116], excp_valid[115], execode[114:110], rt_value[109:78], op_wl[77], op_wr[76], op_w[75], op_bu[74], op_b[73], op_hu[72], op_h[71], res_from_mem[70], gr_we[69], dest[68:64], result[63:32], pc[31:0]}
- ms_to_ws_valid  out  1  bundle valid to WB
- ms_to_ws_bus  out  120  {excp_bvaddr[119:88], bd[87], cp0_dest[86:79], eret[78], mtc0[77], mfc0[76], excp_valid[75], execode[74:70], gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
- ms_to_ds_fw_bus  out  39  {is_mfc0_or_load_pending[38], gr_we[37], dest[36:32], final_result[31:0]}
- out_ms_valid  out  1  raw ms_valid
- ms_excp_valid  out  1  ms_valid && (excp_valid || eret); EXE uses it to kill stores
- ws_flush  in  1  exception/eret commit in WB; squashes MEM
- data_sram_rdata  in  32  read data for the address EXE drove one cycle earlier

## Operation
- Registers: ms_valid, bus_r (160b), first_cycle, rdata_buf (32b), buf_valid.
- ms_ready_go = 1. ms_allowin = !ms_valid || ws_allowin. ms_to_ws_valid = ms_valid.
- Acceptance: when ms_allowin, ms_valid <= es_to_ms_valid; on es_to_ms_valid && ms_allowin, bus_r <= es_to_ms_bus, first_cycle <= 1, buf_valid <= 0.
- Flush: ws_flush forces ms_valid <= 0 next edge, priority over acceptance; buf_valid <= 0.
- Hold buffer: when ms_valid && first_cycle && !ws_allowin, rdata_buf <= data_sram_rdata, buf_valid <= 1. first_cycle <= 0 on any edge not accepting a new instruction. Effective rdata = buf_valid ? rdata_buf : data_sram_rdata.
- Alignment, k = result[1:0], rt = rt_value:
  - op_w: rdata. op_b/op_bu: byte k, sign/zero-extended. op_h/op_hu: halfword k[1] (k[0]=0 guaranteed by EXE), sign/zero-extended.
  - op_wl: k0 {rdata[7:0],rt[23:0]}; k1 {rdata[15:0],rt[15:0]}; k2 {rdata[23:0],rt[7:0]}; k3 rdata.
  - op_wr: k0 rdata; k1 {rt[31:24],rdata[31:8]}; k2 {rt[31:16],rdata[31:16]}; k3 {rt[31:8],rdata[31:24]}.
- final_result = res_from_mem ? aligned load : result.
- Outgoing gr_we = bus gr_we && !excp_valid. Exception fields pass through unchanged.
- Forward bus: gr_we bit = ms_valid && outgoing gr_we; bit 38 = ms_valid && mfc0 (decode must stall, not forward).

## Timing
- Reset (async): ms_valid=0, first_cycle=0, buf_valid=0, bus_r=0, rdata_buf=0. Outputs: ms_allowin=1, ms_to_ws_valid=0, ms_excp_valid=0, fw gr_we=0, bit38=0.
- Latency: one cycle in MEM when ws_allowin=1; load result combinationally available in the entry cycle.
- Stall N cycles: rdata captured at end of entry cycle; final_result stable for all N+1 cycles regardless of data_sram_rdata changes.
- Back-to-back: new instruction accepted same edge old one leaves; buf_valid cleared for the new one.
- Simultaneous ws_flush and es_to_ms_valid: MEM empty next cycle.
- Reset mid-stall: all state cleared immediately; no bundle presented.

## Test plan
- lw at addr 0x...04, rdata=0x8899AABB, ws_allowin=1 -> ms_to_ws_bus final_result=0x8899AABB, gr_we=1, one cycle later ms_valid=0 if no follow-on.
- lb k=3, rdata=0x80112233 -> 0xFFFFFF80; lbu same -> 0x00000080; lh k=2 -> 0xFFFF8011.
- lwl k=1, rt=0x11223344, rdata=0xAABBCCDD -> 0xCCDD3344; lwr k=2 same inputs -> 0x1122AABB.
- lw entering with ws_allowin=0 for 3 cycles, data_sram_rdata changing to 0xDEADBEEF after cycle 1 -> final_result holds original value all 4 cycles, ms_allowin=0 until release.
- Bus with excp_valid=1, execode=0x04, gr_we=1 -> outgoing gr_we=0, ms_excp_valid=1, execode=0x04; ws_flush asserted -> ms_valid=0 next edge.
- reset asserted mid-stall (async, between edges) -> ms_to_ws_valid=0 and ms_allowin=1 immediately.
